uart_pwm_ctrl: RTL and testbench
================================

# uart_pwm_ctrl

UART-commanded pulse generator. Serial bytes arrive on `i_uart_rx` (8N1, LSB first) and are assembled into an 18-byte command frame carrying a PWM period, a high time and a pulse count. A valid frame plays out exactly that many PWM pulses on `o_pwm`. It is the top-level block between the host UART line and the driven output, for example a buzzer.

## Interface
- CLK_FREQ, 50_000_000: clock frequency in Hz.
- UART_BPS_RATE, 115200: baud rate (≤115200).
- BIT_CYC, CLK_FREQ/UART_BPS_RATE (434): clocks per bit, integer division (localparam).

- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_uart_rx  in  1  UART receive line, idle high, asynchronous to i_clk.
- o_pwm  out  1  pulse output. Reset value 0.

## Operation
- **RX front end**
  - i_uart_rx passes through a 2-FF synchronizer; the sync flops reset to 1.
  - RX FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on a synchronized falling edge.
  - START: at BIT_CYC/2 (217) clocks, the line is re-sampled. If it is high, the edge was a glitch: go back to IDLE. If it is low, go to DATA.
  - DATA: sample 8 bits, each BIT_CYC clocks after the previous sample (bit centres), LSB first.
  - STOP: sample one bit-time later.
    - Stop bit = 1: emit a one-cycle byte strobe with the data, then go to IDLE.
    - Stop bit = 0 (framing error): drop the byte and go to IDLE.
- **Frame decoder** (byte index 0..17)
  - Bytes 0-3: header AA 55 A5 5A.
  - Bytes 4-7: PERIOD[31:0], MSB first.
  - Bytes 8-11: HIGH[31:0], MSB first.
  - Bytes 12-13: NUM[15:0], MSB first.
  - Bytes 14-17: tail CC 33 C3 3C.
  - Header mismatch: index returns to 0. If the mismatching byte is 0xAA, it counts as byte 0 and the index becomes 1.
  - Tail mismatch: the frame is discarded, index returns to 0, the active configuration is unchanged.
  - Payload bytes shift into shadow registers. Shadow values are copied to the active registers only when byte 17 matches; a one-cycle `load` pulse is issued at the same time.
  - No inter-byte timeout.
- **PWM engine**
  - States: IDLE, RUN.
  - On `load`:
    - PERIOD=0 or NUM=0: go to or stay in IDLE with o_pwm=0.
    - Otherwise: period counter = 0, pulse counter = 0, enter RUN. This applies even if the engine is already in RUN, so a new frame aborts the current burst and restarts.
  - RUN:
    - Period counter runs 0..PERIOD-1.
    - o_pwm = 1 while counter < HIGH, otherwise 0.
    - When the counter reaches PERIOD-1 it wraps and the pulse counter increments.
    - After NUM complete periods: go to IDLE, o_pwm=0.
  - Arithmetic is 32-bit unsigned.
    - HIGH ≥ PERIOD: output is high for the whole burst.
    - HIGH = 0: output stays low but the burst still lasts NUM×PERIOD clocks.
  - o_pwm is registered.
- **Reset** (at any time, including mid-byte or mid-burst):
  - All FSMs return to IDLE.
  - Counters and shadow/active registers clear to 0.
  - o_pwm = 0.

## Timing
- Byte strobe: at the stop-bit sample, about 9.5×BIT_CYC clocks after the start edge (plus 2 synchronizer clocks).
- `load`: 1 clock after the strobe of 0x3C.
- First o_pwm rise: 1 clock after `load`.
- Each pulse is high for exactly HIGH clocks in every PERIOD clocks.
- Burst length: NUM×PERIOD clocks, then o_pwm held at 0.
- Back-to-back bytes with a single stop bit are received without loss. A new start edge is accepted from the clock after the stop sample.

## Test plan
- **Normal frame:** reset 1 µs. Send AA 55 A5 5A, PERIOD=1000, HIGH=100, NUM=5, CC 33 C3 3C at 115200. Required: 5 pulses, each 100 clk (2 µs) high with a 1000 clk (20 µs) period, then o_pwm=0.
- **Second frame:** 1 ms later, PERIOD=5000, HIGH=1000, NUM=5. Required: 5 pulses, 20 µs high with a 100 µs period.
- **Corrupt tail:** tail byte 3 = 0x3D. Required: no pulses, previous configuration not applied. A following valid frame works.
- **Garbage then header:** stray bytes 12 AA, then a full valid frame. Required: the frame decodes correctly.
- **Degenerate values:**
  - NUM=0: no output.
  - HIGH=1200 with PERIOD=1000, NUM=2: o_pwm high for 2000 clk.
- **Restart and reset:**
  - A new frame mid-burst restarts with the new parameters.
  - i_rst asserted mid-burst forces o_pwm=0 immediately. After release, no output occurs until a new frame arrives.

Source files
------------

// File: rtl/uart_pwm_ctrl.sv
// UART-commanded PWM burst generator: an 8N1 receiver feeds an 18-byte frame decoder,
// and each valid frame starts a burst of NUM pulses of PERIOD clocks with HIGH clocks high.
module uart_pwm_ctrl #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int UART_BPS_RATE = 115200
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_uart_rx,
  output logic o_pwm
);

  localparam int BIT_CYC = CLK_FREQ / UART_BPS_RATE;
  localparam int CNT_W   = $clog2(BIT_CYC) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYC / 2 - 1);

  function automatic logic [7:0] hdr_byte(input logic [4:0] idx);
    case (idx)
      5'd0:    hdr_byte = 8'hAA;
      5'd1:    hdr_byte = 8'h55;
      5'd2:    hdr_byte = 8'hA5;
      default: hdr_byte = 8'h5A;
    endcase
  endfunction

  function automatic logic [7:0] tail_byte(input logic [4:0] idx);
    case (idx)
      5'd14:   tail_byte = 8'hCC;
      5'd15:   tail_byte = 8'h33;
      5'd16:   tail_byte = 8'hC3;
      default: tail_byte = 8'h3C;
    endcase
  endfunction

  // RX line synchronizer; rx_d is one extra delay for falling-edge detection
  logic rx_s1, rx_s2, rx_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= i_uart_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // RX FSM: bit-centre sampling, byte strobe only when the stop bit is high
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_vld;
  logic [7:0]       rx_byte;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_vld   <= 1'b0;
      rx_byte  <= '0;
    end else begin
      rx_vld <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_d && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_s2) begin
              rx_vld  <= 1'b1;
              rx_byte <= rx_shift;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Frame decoder: payload lands in shadow registers, committed only on a full tail match
  logic [4:0]  fr_idx;
  logic [31:0] sh_period, sh_high, act_period, act_high;
  logic [15:0] sh_num, act_num;
  logic        load;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fr_idx     <= '0;
      sh_period  <= '0;
      sh_high    <= '0;
      sh_num     <= '0;
      act_period <= '0;
      act_high   <= '0;
      act_num    <= '0;
      load       <= 1'b0;
    end else begin
      load <= 1'b0;
      if (rx_vld) begin
        if (fr_idx < 5'd4) begin
          if (rx_byte == hdr_byte(fr_idx)) fr_idx <= fr_idx + 5'd1;
          else                             fr_idx <= (rx_byte == 8'hAA) ? 5'd1 : 5'd0;
        end else if (fr_idx < 5'd8) begin
          sh_period <= {sh_period[23:0], rx_byte};
          fr_idx    <= fr_idx + 5'd1;
        end else if (fr_idx < 5'd12) begin
          sh_high <= {sh_high[23:0], rx_byte};
          fr_idx  <= fr_idx + 5'd1;
        end else if (fr_idx < 5'd14) begin
          sh_num <= {sh_num[7:0], rx_byte};
          fr_idx <= fr_idx + 5'd1;
        end else if (fr_idx < 5'd17) begin
          fr_idx <= (rx_byte == tail_byte(fr_idx)) ? fr_idx + 5'd1 : 5'd0;
        end else begin
          fr_idx <= '0;
          if (rx_byte == tail_byte(fr_idx)) begin
            act_period <= sh_period;
            act_high   <= sh_high;
            act_num    <= sh_num;
            load       <= 1'b1;
          end
        end
      end
    end
  end

  // PWM engine: o_pwm is registered in phase with p_cnt; a load always restarts the burst
  typedef enum logic {PWM_IDLE, PWM_RUN} pwm_state_t;

  pwm_state_t  pwm_state;
  logic [31:0] p_cnt;
  logic [15:0] n_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pwm_state <= PWM_IDLE;
      p_cnt     <= '0;
      n_cnt     <= '0;
      o_pwm     <= 1'b0;
    end else if (load) begin
      p_cnt <= '0;
      n_cnt <= '0;
      if (act_period == 32'd0 || act_num == 16'd0) begin
        pwm_state <= PWM_IDLE;
        o_pwm     <= 1'b0;
      end else begin
        pwm_state <= PWM_RUN;
        o_pwm     <= (act_high != 32'd0);
      end
    end else if (pwm_state == PWM_RUN) begin
      if (p_cnt == act_period - 32'd1) begin
        p_cnt <= '0;
        if (n_cnt == act_num - 16'd1) begin
          pwm_state <= PWM_IDLE;
          o_pwm     <= 1'b0;
        end else begin
          n_cnt <= n_cnt + 16'd1;
          o_pwm <= (act_high != 32'd0);
        end
      end else begin
        p_cnt <= p_cnt + 32'd1;
        o_pwm <= ((p_cnt + 32'd1) < act_high);
      end
    end else begin
      o_pwm <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_pwm_ctrl.sv
// Directed bench for uart_pwm_ctrl: sends frames over a fast UART and measures the pulse train.
`timescale 1ns/1ps
module tb_uart_pwm_ctrl;

  localparam int BIT = 10;  // 1_152_000 / 115200

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic pwm;

  int n_checks = 0;
  int n_errors = 0;

  uart_pwm_ctrl #(.CLK_FREQ(1_152_000), .UART_BPS_RATE(115200)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_uart_rx (rx),
    .o_pwm     (pwm)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled on the falling edge
  int   cyc = 0;
  logic mon_clr = 1'b0;
  logic pwm_q = 1'b0;
  int   highs = 0;
  int   last_fall = 0;
  int   rise_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_clr) begin
      highs     <= 0;
      last_fall <= 0;
      rise_q.delete();
      pwm_q     <= pwm;
    end else begin
      if (pwm) highs <= highs + 1;
      if (pwm && !pwm_q) rise_q.push_back(cyc);
      if (!pwm && pwm_q) last_fall <= cyc;
      pwm_q <= pwm;
    end
  end

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk); mon_clr = 1'b1;
    @(posedge clk); mon_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] per, input logic [31:0] hi,
                            input logic [15:0] num, input logic [7:0] t3);
    logic [7:0] fb [18];
    fb = '{8'hAA, 8'h55, 8'hA5, 8'h5A,
           per[31:24], per[23:16], per[15:8], per[7:0],
           hi[31:24], hi[23:16], hi[15:8], hi[7:0],
           num[15:8], num[7:0],
           8'hCC, 8'h33, 8'hC3, t3};
    for (int i = 0; i < 18; i++) send_byte(fb[i]);
  endtask

  task automatic check_burst(input string tag, input int nrise, input int nhigh,
                             input int span, input int width);
    int n;
    n = rise_q.size();
    check_val({tag, "_rises"}, n, nrise);
    check_val({tag, "_highs"}, highs, nhigh);
    check_val({tag, "_span"}, (n > 0) ? rise_q[n-1] - rise_q[0] : -1, span);
    check_val({tag, "_width"}, (n > 0) ? last_fall - rise_q[n-1] : -1, width);
    check_val({tag, "_idle"}, pwm, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_val("reset_pwm", pwm, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_val("post_reset_pwm", pwm, 0);

    // Normal frame
    clear_mon();
    send_frame(32'd100, 32'd10, 16'd5, 8'h3C);
    repeat (600) @(negedge clk);
    check_burst("normal", 5, 50, 400, 10);

    // Second frame
    clear_mon();
    send_frame(32'd50, 32'd20, 16'd3, 8'h3C);
    repeat (200) @(negedge clk);
    check_burst("second", 3, 60, 100, 20);

    // Corrupt tail, then a valid frame
    clear_mon();
    send_frame(32'd40, 32'd10, 16'd4, 8'h3D);
    repeat (300) @(negedge clk);
    check_val("corrupt_rises", rise_q.size(), 0);
    check_val("corrupt_highs", highs, 0);
    clear_mon();
    send_frame(32'd30, 32'd5, 16'd2, 8'h3C);
    repeat (150) @(negedge clk);
    check_burst("after_corrupt", 2, 10, 30, 5);

    // Garbage then header
    clear_mon();
    send_byte(8'h12);
    send_byte(8'hAA);
    send_frame(32'd20, 32'd7, 16'd3, 8'h3C);
    repeat (150) @(negedge clk);
    check_burst("garbage", 3, 21, 40, 7);

    // NUM = 0
    clear_mon();
    send_frame(32'd100, 32'd10, 16'd0, 8'h3C);
    repeat (300) @(negedge clk);
    check_val("num0_rises", rise_q.size(), 0);
    check_val("num0_highs", highs, 0);

    // HIGH >= PERIOD
    clear_mon();
    send_frame(32'd100, 32'd120, 16'd2, 8'h3C);
    repeat (300) @(negedge clk);
    check_burst("high_ge_per", 1, 200, 0, 200);

    // Restart mid-burst: the old burst is still running when the second frame loads
    send_frame(32'd170, 32'd5, 16'd20, 8'h3C);
    clear_mon();
    send_frame(32'd30, 32'd10, 16'd2, 8'h3C);
    repeat (100) @(negedge clk);
    check_val("restart_rise_gap",
              (rise_q.size() >= 2) ? rise_q[rise_q.size()-1] - rise_q[rise_q.size()-2] : -1, 30);
    check_val("restart_width",
              (rise_q.size() >= 1) ? last_fall - rise_q[rise_q.size()-1] : -1, 10);
    clear_mon();
    repeat (2000) @(negedge clk);
    check_val("restart_old_gone", rise_q.size(), 0);

    // Reset mid-burst
    send_frame(32'd100, 32'd50, 16'd20, 8'h3C);
    for (int i = 0; i < 200 && !pwm; i++) @(negedge clk);
    check_val("rst_burst_high", pwm, 1);
    #3 rst = 1'b1;
    #1 check_val("rst_async_low", pwm, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    repeat (2500) @(negedge clk);
    check_val("rst_no_rises", rise_q.size(), 0);
    check_val("rst_no_highs", highs, 0);
    clear_mon();
    send_frame(32'd10, 32'd3, 16'd2, 8'h3C);
    repeat (60) @(negedge clk);
    check_burst("after_rst", 2, 6, 10, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
